// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@72 Hz raster timing.
// Counts pixels and lines, decodes the active area and both sync pulses, and
// delays the sync and blank flags to line up with the scaler's registered
// colour output.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter bit SYNC_POL   = 1'b1,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compare constants sized to the counters.
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_reg;
  logic [10:0] h_cnt_next;
  logic [9:0]  v_cnt_reg;
  logic [9:0]  v_cnt_next;
  logic        h_last;
  logic        v_last;
  logic        act_next;
  logic        hs_next;
  logic        vs_next;
  logic        act_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic        line_start_reg;
  logic        frame_start_reg;
  logic        act_dly;
  logic        hs_dly;
  logic        vs_dly;

  assign h_last = (h_cnt_reg == H_LAST);
  assign v_last = (v_cnt_reg == V_LAST);

  // Next counter values: h wraps at the line end and carries into v.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_ce) begin
      if (h_last) begin
        h_cnt_next = '0;
        v_cnt_next = v_last ? '0 : v_cnt_reg + 10'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 11'd1;
      end
    end
  end

  // Decode from the next counts so the registered flags match the counters.
  always_comb begin
    act_next = (h_cnt_next < H_ACT) && (v_cnt_next < V_ACT);
    hs_next  = (h_cnt_next >= HS_BEG) && (h_cnt_next < HS_END);
    vs_next  = (v_cnt_next >= VS_BEG) && (v_cnt_next < VS_END);
  end

  // Counters, raw flags and the undelayed line/frame pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      act_reg         <= 1'b0;
      hs_reg          <= 1'b0;
      vs_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      // Pulses last one clk even if pix_ce drops right after the wrap.
      line_start_reg  <= pix_ce & h_last;
      frame_start_reg <= pix_ce & h_last & v_last;
      if (pix_ce) begin
        h_cnt_reg <= h_cnt_next;
        v_cnt_reg <= v_cnt_next;
        act_reg   <= act_next;
        hs_reg    <= hs_next;
        vs_reg    <= vs_next;
      end
    end
  end

  // Delay line runs every clk so the lag is fixed in clk cycles, not pixels.
  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign {act_dly, hs_dly, vs_dly} = {act_reg, hs_reg, vs_reg};
    end else begin : g_dly
      for (genvar gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
        logic [2:0] d;
        logic [2:0] q_reg;
        if (gi == 0) begin : g_first
          assign d = {act_reg, hs_reg, vs_reg};
        end else begin : g_rest
          assign d = g_stage[gi-1].q_reg;
        end
        // One shift stage; reset flushes it to inactive.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            q_reg <= 3'b000;
          end else begin
            q_reg <= d;
          end
        end
      end
      assign {act_dly, hs_dly, vs_dly} = g_stage[PIPE_DELAY-1].q_reg;
    end
  endgenerate

  assign pixel_x     = (h_cnt_reg < H_ACT) ? h_cnt_reg[9:0] : 10'd0;
  assign pixel_y     = (v_cnt_reg < V_ACT) ? v_cnt_reg : 10'd0;
  assign hsync       = hs_dly ? SYNC_POL : ~SYNC_POL;
  assign vsync       = vs_dly ? SYNC_POL : ~SYNC_POL;
  assign video_on    = act_dly;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule
